// File: rtl/alu_wide_seq.sv
// Sequencer that runs a 2*bits_size-wide ALU request through an external
// bits_size ALU in two passes (low half, then high half with carry chaining).
module alu_wide_seq #(
    parameter int bits_size  = 32,
    parameter int cntrl_size = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [cntrl_size-1:0]   req_op,
    input  logic [2*bits_size-1:0]  req_a,
    input  logic [2*bits_size-1:0]  req_b,
    output logic [bits_size-1:0]    A,
    output logic [bits_size-1:0]    B,
    output logic [cntrl_size-1:0]   Alu_Cntrl,
    output logic                    Cin,
    input  logic [bits_size-1:0]    OUT,
    input  logic                    Zero,
    input  logic                    Carry,
    input  logic                    oVerflow,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*bits_size-1:0]  rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_carry,
    output logic                    rsp_overflow,
    output logic                    rsp_negative,
    output logic                    rsp_err,
    output logic [15:0]             ops_done
);

    localparam int W = 2 * bits_size;

    localparam logic [cntrl_size-1:0] OP_EQU = cntrl_size'(4'b0000);
    localparam logic [cntrl_size-1:0] OP_ADD = cntrl_size'(4'b0101);
    localparam logic [cntrl_size-1:0] OP_SUB = cntrl_size'(4'b0111);
    localparam logic [cntrl_size-1:0] OP_OR  = cntrl_size'(4'b1011);
    localparam logic [cntrl_size-1:0] OP_XOR = cntrl_size'(4'b1100);
    localparam logic [cntrl_size-1:0] OP_AND = cntrl_size'(4'b1101);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t                 state;
    logic [cntrl_size-1:0]  op_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [bits_size-1:0]   lo_out;
    logic [bits_size-1:0]   hi_out;
    logic                   lo_carry;
    logic                   lo_zero;
    logic                   hi_carry;
    logic                   hi_zero;
    logic                   hi_ovf;
    logic                   err_q;

    logic                   op_sub;
    logic                   op_arith;
    logic [W-1:0]           wide;
    logic [W-1:0]           nxt_result;
    logic                   nxt_zero;
    logic                   nxt_carry;
    logic                   nxt_overflow;
    logic                   nxt_negative;
    logic                   nxt_err;

    function automatic logic supported(input logic [cntrl_size-1:0] op);
        return (op == OP_EQU) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_AND);
    endfunction

    // Subtraction is done as A + ~B + 1, so the ALU only ever sees ADD.
    function automatic logic [cntrl_size-1:0] alu_code(input logic [cntrl_size-1:0] op);
        return (op == OP_SUB) ? OP_ADD : op;
    endfunction

    function automatic logic [bits_size-1:0] b_pass(input logic [bits_size-1:0] half,
                                                    input logic invert);
        return invert ? ~half : half;
    endfunction

    assign req_ready = (state == IDLE);
    assign op_sub    = (op_q == OP_SUB);
    assign op_arith  = (op_q == OP_ADD) || op_sub;
    assign wide      = {hi_out, lo_out};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        nxt_result   = '0;
        nxt_zero     = 1'b0;
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        nxt_negative = 1'b0;
        nxt_err      = 1'b0;
        if (err_q) begin
            nxt_err = 1'b1;
        end else if (op_q == OP_EQU) begin
            nxt_zero = lo_zero & hi_zero;
        end else begin
            nxt_result   = wide;
            nxt_zero     = (wide == '0);
            nxt_negative = wide[W-1];
            if (op_arith) begin
                nxt_carry    = hi_carry;
                nxt_overflow = hi_ovf;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            lo_out       <= '0;
            hi_out       <= '0;
            lo_carry     <= 1'b0;
            lo_zero      <= 1'b0;
            hi_carry     <= 1'b0;
            hi_zero      <= 1'b0;
            hi_ovf       <= 1'b0;
            err_q        <= 1'b0;
            A            <= '0;
            B            <= '0;
            Alu_Cntrl    <= '0;
            Cin          <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_err      <= 1'b0;
            ops_done     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (supported(req_op)) begin
                            err_q     <= 1'b0;
                            A         <= req_a[bits_size-1:0];
                            B         <= b_pass(req_b[bits_size-1:0], req_op == OP_SUB);
                            Alu_Cntrl <= alu_code(req_op);
                            Cin       <= (req_op == OP_SUB);
                            state     <= LO;
                        end else begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                LO: begin
                    lo_out   <= OUT;
                    lo_carry <= Carry;
                    lo_zero  <= Zero;
                    A        <= a_q[W-1:bits_size];
                    B        <= b_pass(b_q[W-1:bits_size], op_sub);
                    Cin      <= op_arith ? Carry : 1'b0;
                    state    <= HI;
                end
                HI: begin
                    hi_out    <= OUT;
                    hi_carry  <= Carry;
                    hi_zero   <= Zero;
                    hi_ovf    <= oVerflow;
                    A         <= '0;
                    B         <= '0;
                    Alu_Cntrl <= '0;
                    Cin       <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    // First RESP cycle publishes the response; it then holds until taken.
                    if (!rsp_valid) begin
                        rsp_valid    <= 1'b1;
                        rsp_result   <= nxt_result;
                        rsp_zero     <= nxt_zero;
                        rsp_carry    <= nxt_carry;
                        rsp_overflow <= nxt_overflow;
                        rsp_negative <= nxt_negative;
                        rsp_err      <= nxt_err;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // lo_carry is kept for visibility of the low pass; the chained carry is taken live.
    logic unused_ok;
    assign unused_ok = lo_carry;

endmodule
